// File: rtl/prio_arb_pkg.sv
// Shared types and constants for the registered N-way priority arbiter.
package prio_arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational highest-set-bit finder: returns the index of the highest
// asserted request and whether any request is asserted at all.
module prio_pick #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         found
);

   // NOTE: every always_comb output gets a default before any conditional
   // assignment, otherwise an unassigned path infers a latch.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter, fixed-priority or round-robin, whose grant is
// held under a valid/ack handshake.
module prio_arbiter #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         ack,
   output logic         grant_valid,
   output logic [W-1:0] grant_idx,
   output logic [N-1:0] grant_onehot
);

   import prio_arb_pkg::*;

   localparam logic [N-1:0] ONE_HOT_0 = N'(1);
   localparam logic [W:0]   N_WIDE    = (W+1)'(N);

   arb_state_t     state;
   logic [W-1:0]   last;
   logic [W-1:0]   rot;
   logic [2*N-1:0] doubled;
   logic [N-1:0]   rotated;
   logic [W-1:0]   pick_idx;
   logic           pick_found;
   logic [W:0]     sum;
   logic [W-1:0]   winner;
   logic           acked;

   assign acked = (state == GRANT) && ack;

   // On a back-to-back ack in RR the search must already see the pointer
   // moved to the channel being acked, so it bypasses the register.
   always_comb begin
      rot = '0;
      if (mode == MODE_RR) rot = acked ? grant_idx : last;
   end

   // Rotating right by the pointer puts channel (last-1) mod N at the top,
   // so the highest-set-bit finder walks downward with wrap-around.
   assign doubled = {req, req} >> rot;
   assign rotated = doubled[N-1:0];

   prio_pick #(.N(N), .W(W)) u_pick (
      .req   (rotated),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      sum = {1'b0, pick_idx} + {1'b0, rot};
      if (sum >= N_WIDE) sum = sum - N_WIDE;
      winner = sum[W-1:0];
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last         <= '0;
         grant_valid  <= 1'b0;
         grant_idx    <= '0;
         grant_onehot <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state        <= GRANT;
                  grant_valid  <= 1'b1;
                  grant_idx    <= winner;
                  grant_onehot <= ONE_HOT_0 << winner;
               end
            end
            GRANT: begin
               if (ack) begin
                  if (mode == MODE_RR) last <= grant_idx;
                  if (pick_found) begin
                     grant_idx    <= winner;
                     grant_onehot <= ONE_HOT_0 << winner;
                  end else begin
                     state        <= IDLE;
                     grant_valid  <= 1'b0;
                     grant_idx    <= '0;
                     grant_onehot <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter (N=4): a search-order model compared
// every cycle, plus directed vectors with literal expected grants.
module tb_prio_arbiter;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic         mode;
   logic         ack;
   logic         grant_valid;
   logic [W-1:0] grant_idx;
   logic [N-1:0] grant_onehot;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: what the arbiter must be presenting after each edge.
   bit m_valid;
   int m_idx;
   int m_last;

   prio_arbiter #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .mode         (mode),
      .ack          (ack),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .grant_onehot (grant_onehot)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Walk downward from (ptr-1) mod N with wrap; first requester wins.
   function automatic bit model_pick(input logic [N-1:0] r, input int ptr, output int ch);
      ch = 0;
      for (int j = 1; j <= N; j++) begin
         int c;
         c = (ptr - j + N) % N;
         if (r[c]) begin
            ch = c;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_idx   = 0;
         m_last  = 0;
      end else if (!m_valid || ack) begin
         int ch;
         if (m_valid && mode) m_last = m_idx;
         if (model_pick(req, mode ? m_last : 0, ch)) begin
            m_valid = 1'b1;
            m_idx   = ch;
         end else begin
            m_valid = 1'b0;
            m_idx   = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("model_valid",  32'(grant_valid),  32'(m_valid));
         check("model_idx",    32'(grant_idx),    32'(m_idx));
         check("model_onehot", 32'(grant_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
      end
   end

   task automatic step(input logic [N-1:0] r, input logic m, input logic a);
      req  = r;
      mode = m;
      ack  = a;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input string name, input logic v, input int idx);
      check({name, "_valid"},  32'(grant_valid),  32'(v));
      check({name, "_idx"},    32'(grant_idx),    32'(idx));
      check({name, "_onehot"}, 32'(grant_onehot), v ? (32'd1 << idx) : 32'd0);
   endtask

   task automatic do_reset();
      req   = '0;
      mode  = 1'b0;
      ack   = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();
      expect_grant("reset", 1'b0, 0);

      // Fixed, all requesting, no ack: idx 3 held.
      step(4'b1111, 1'b0, 1'b0); expect_grant("fix_all_c1", 1'b1, 3);
      step(4'b1111, 1'b0, 1'b0); expect_grant("fix_all_c2", 1'b1, 3);
      step(4'b1111, 1'b0, 1'b0); expect_grant("fix_all_c3", 1'b1, 3);
      step(4'b0000, 1'b0, 1'b1); expect_grant("fix_all_end", 1'b0, 0);

      // Fixed back-to-back: acked channel may win again.
      step(4'b0111, 1'b0, 1'b0); expect_grant("fix_b2b_1", 1'b1, 2);
      step(4'b0111, 1'b0, 1'b1); expect_grant("fix_b2b_2", 1'b1, 2);
      step(4'b0000, 1'b0, 1'b1); expect_grant("fix_b2b_end", 1'b0, 0);

      // RR full rotation with ack held high.
      step(4'b1111, 1'b1, 1'b0); expect_grant("rr_all_0", 1'b1, 3);
      step(4'b1111, 1'b1, 1'b1); expect_grant("rr_all_1", 1'b1, 2);
      step(4'b1111, 1'b1, 1'b1); expect_grant("rr_all_2", 1'b1, 1);
      step(4'b1111, 1'b1, 1'b1); expect_grant("rr_all_3", 1'b1, 0);
      step(4'b1111, 1'b1, 1'b1); expect_grant("rr_all_4", 1'b1, 3);
      step(4'b0000, 1'b1, 1'b1); expect_grant("rr_all_end", 1'b0, 0);

      // RR alternating pair, then switch to fixed mid-stream.
      do_reset();
      step(4'b1001, 1'b1, 1'b0); expect_grant("rr_pair_0", 1'b1, 3);
      step(4'b1001, 1'b1, 1'b1); expect_grant("rr_pair_1", 1'b1, 0);
      step(4'b1001, 1'b1, 1'b1); expect_grant("rr_pair_2", 1'b1, 3);
      step(4'b1001, 1'b1, 1'b1); expect_grant("rr_pair_3", 1'b1, 0);
      step(4'b1001, 1'b0, 1'b1); expect_grant("pair_fix_0", 1'b1, 3);
      step(4'b1001, 1'b0, 1'b1); expect_grant("pair_fix_1", 1'b1, 3);
      step(4'b0000, 1'b0, 1'b1); expect_grant("pair_end", 1'b0, 0);

      // Locked grant: request withdrawn, ack delayed; ack ignored in IDLE.
      step(4'b0001, 1'b0, 1'b0); expect_grant("lock_1", 1'b1, 0);
      step(4'b0000, 1'b0, 1'b0); expect_grant("lock_2", 1'b1, 0);
      step(4'b0000, 1'b0, 1'b0); expect_grant("lock_3", 1'b1, 0);
      step(4'b0000, 1'b0, 1'b0); expect_grant("lock_4", 1'b1, 0);
      step(4'b0000, 1'b0, 1'b1); expect_grant("lock_idle", 1'b0, 0);
      step(4'b0000, 1'b0, 1'b1); expect_grant("idle_ack", 1'b0, 0);

      // RR: bring pointer to 1 while in GRANT, then reset asynchronously.
      do_reset();
      step(4'b0110, 1'b1, 1'b0); expect_grant("rst_setup_0", 1'b1, 2);
      step(4'b0110, 1'b1, 1'b1); expect_grant("rst_setup_1", 1'b1, 1);
      step(4'b1111, 1'b1, 1'b1); expect_grant("rst_setup_2", 1'b1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      expect_grant("async_rst", 1'b0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(4'b1111, 1'b1, 1'b0); expect_grant("post_rst", 1'b1, 3);
      step(4'b1111, 1'b1, 1'b1); expect_grant("post_rst_rr", 1'b1, 2);
      step(4'b0000, 1'b1, 1'b1); expect_grant("post_rst_end", 1'b0, 0);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Parametrised, registered N-way priority arbiter: the sequential successor to the 4-to-2 combinational priority encoder. It picks one of N request lines in either fixed-priority mode (highest index wins, same ordering as the encoder) or round-robin mode. The winner is held under a valid/ack handshake. It sits in front of any shared resource (bus, FIFO port) that the datapath must time-share.

## Interface
- `N`, default 8: number of request channels, ≥2.
- `W`, default `$clog2(N)`: index width; derived, do not override.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  N  request vector, bit i = channel i.
- `mode`  in  1  0 = fixed priority, 1 = round-robin.
- `ack`  in  1  consumer accepts the current grant.
- `grant_valid`  out  1  a grant is being presented.
- `grant_idx`  out  W  binary index of the granted channel.
- `grant_onehot`  out  N  one-hot grant; all-zero when `grant_valid`=0.

## Operation
- FSM with 2 states.
  - IDLE: if `|req`, arbitrate, latch the winner, go to GRANT; else stay.
  - GRANT: hold `grant_idx`/`grant_onehot` stable until `ack`=1. On ack:
    - update the RR pointer to the granted index;
    - if `|req` (current sample), arbitrate again and stay in GRANT with the new winner (back-to-back);
    - else go to IDLE.
- Fixed mode: winner = highest set index of `req`.
- RR mode: search starts at `(last-1) mod N` and proceeds downward with wrap-around. `last` resets to 0, so the first RR search starts at N-1 and matches fixed mode.
- Fixed mode never updates `last`. RR mode updates `last` only on ack.
- In back-to-back arbitration the acked channel's req is eligible. In RR it has lowest priority; in fixed mode it may win again.
- Grant is locked: dropping `req[grant_idx]` before ack does not withdraw the grant.
- `ack` is ignored in IDLE.
- `mode` is sampled only at arbitration instants. A change during GRANT affects the next arbitration only.

## Timing
- All outputs are registered. Reset values: `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0, `last`=0, state=IDLE.
- Latency is 1 cycle: a req sampled at edge k gives `grant_valid`=1 after edge k.
- Throughput is one grant per cycle when ack is held high and requests are pending.
- Reset asserted mid-GRANT clears outputs immediately (asynchronous). After release, the first edge with `|req` arbitrates from the reset pointer.
- `grant_idx` and `grant_onehot` always encode the same channel.

## Structure
- Package `prio_arb_pkg`:
  - `typedef enum logic {IDLE, GRANT} arb_state_t`
  - `localparam MODE_FIXED = 1'b0`, `MODE_RR = 1'b1`
- Sub-module `prio_pick #(N)`: combinational highest-set-bit finder returning index and found flag.
  - RR is implemented by rotating `req` by the pointer, calling `prio_pick`, then un-rotating the index.
  - Fixed mode uses zero rotation.

## Test plan
All scenarios use N=4.
- Fixed, `req`=1111, no ack for 3 cycles: `grant_valid`=1, `grant_idx`=3, `grant_onehot`=1000 one cycle after req, and stable for all 3 cycles.
- Fixed, `req`=0111, ack pulsed 1 cycle with req held: `grant_idx`=2, then 2 again on the next cycle (back-to-back); req=0000 at ack gives `grant_valid`=0.
- RR, `req`=1111 constant, ack held high: `grant_idx` sequence 3, 2, 1, 0, 3, one per cycle.
- RR, `req`=1001, ack every cycle: sequence 3, 0, 3, 0; a switch to fixed mode mid-stream gives 3, 3, ….
- `req`=0001 for one cycle then 0000, ack delayed 4 cycles: grant idx 0 held all 4 cycles, then IDLE with `grant_valid`=0.
- RR, `rst_n` low mid-GRANT (last=1): outputs are 0 before the next edge. After release, `req`=1111 grants idx 3.
